// File: rtl/tx_block_framer.sv
//==============================================================================
// Module      : tx_block_framer
// Description : TX transport-block framer placed between the byte source and
//               the FEC. Each block takes its bytes from one source (AXI-stream,
//               PRBS23 or all-zeros), selected when the block starts. The stream
//               is cut into BLOCK_LEN-byte blocks. A short packet is padded
//               with PAD_BYTE. GAP_LEN idle cycles follow each block.
//               osop/oeop mark the first and last byte of a block. Two wrapping
//               counters record completed blocks and inserted pad bytes.
// Optional    : TX_FRAMER_CRC_EN - when defined, the last two bytes of each
//               block carry CRC-16-CCITT (0x1021, init 0xFFFF, MSB-first,
//               high byte first) computed over the BLOCK_LEN-2 payload bytes.
// Ports       : clk_h          clock
//               rst            asynchronous active-high reset
//               mode_in[1:0]   source select: 0 AXI, 1 PRBS23, 2/3 zeros
//               s_axis_*       AXI-stream byte source (tdata/tvalid/tlast/tready)
//               ireq           downstream ready; a byte moves on oval && ireq
//               oval/odata     output byte and its valid
//               osop/oeop      first / last byte of a transport block
//               blk_cnt        completed blocks (wraps)
//               pad_cnt        pad bytes transferred (wraps)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tx_block_framer #(
    parameter int               DAT_W     = 8,
    parameter int               BLOCK_LEN = 476,
    parameter int               GAP_LEN   = 5,
    parameter logic [DAT_W-1:0] PAD_BYTE  = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk_h,
    input  logic             rst,
    input  logic [1:0]       mode_in,
    input  logic [DAT_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    input  logic             ireq,
    output logic             oval,
    output logic [DAT_W-1:0] odata,
    output logic             osop,
    output logic             oeop,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [CNT_W-1:0] pad_cnt
);

`ifdef TX_FRAMER_CRC_EN
    localparam int PAYLOAD_LEN = BLOCK_LEN - 2;
`else
    localparam int PAYLOAD_LEN = BLOCK_LEN;
`endif
    localparam int IDX_W = $clog2(BLOCK_LEN);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(BLOCK_LEN - 1);
    localparam logic [IDX_W-1:0] PAY_LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    localparam logic [1:0] MODE_AXI  = 2'd0;
    localparam logic [1:0] MODE_PRBS = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_PAD  = 3'd2,
        S_GAP  = 3'd3,
        S_CRC  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [22:0]      prbs_q, prbs_d;
    logic             oval_q, oval_d;
    logic [DAT_W-1:0] odata_q, odata_d;
    logic             osop_q, osop_d;
    logic             oeop_q, oeop_d;
    logic             opad_q, opad_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] pad_q, pad_d;
`ifdef TX_FRAMER_CRC_EN
    logic [15:0]      crc_q, crc_d;
`endif

    logic             w_xfer;
    logic             w_can_load;
    logic             w_load;
    logic [DAT_W-1:0] w_ld_data;
    logic             w_ld_pad;
    logic             w_ld_last;
    logic             w_tready;
    logic [22:0]      w_prbs_next;
    logic [DAT_W-1:0] w_prbs_byte;

`ifdef TX_FRAMER_CRC_EN
    // One CRC-16-CCITT update over a full byte, data MSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc,
                                              input logic [DAT_W-1:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = DAT_W - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // PRBS23 (x^23 + x^18 + 1): DAT_W serial steps per byte, first bit in LSB.
    always_comb begin
        logic [22:0] s;
        s           = prbs_q;
        w_prbs_byte = '0;
        for (int i = 0; i < DAT_W; i++) begin
            w_prbs_byte[i] = s[22];
            s              = {s[21:0], s[22] ^ s[17]};
        end
        w_prbs_next = s;
    end

    assign w_xfer     = oval_q && ireq;
    // The single output register can take a new byte when it is empty or is
    // being drained this cycle, so a keeping-up source sees no bubbles.
    assign w_can_load = !oval_q || ireq;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        prbs_d    = prbs_q;
        oval_d    = oval_q;
        odata_d   = odata_q;
        osop_d    = osop_q;
        oeop_d    = oeop_q;
        opad_d    = opad_q;
        blk_d     = blk_q;
        pad_d     = pad_q;
`ifdef TX_FRAMER_CRC_EN
        crc_d     = crc_q;
`endif
        w_load    = 1'b0;
        w_ld_data = '0;
        w_ld_pad  = 1'b0;
        w_ld_last = 1'b0;
        w_tready  = 1'b0;

        if (w_xfer) begin
            oval_d = 1'b0;
            if (oeop_q) begin
                blk_d = blk_q + CNT_W'(1);
            end
            if (opad_q) begin
                pad_d = pad_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                mode_d  = mode_in;
                idx_d   = '0;
                gap_d   = '0;
`ifdef TX_FRAMER_CRC_EN
                crc_d   = 16'hFFFF;
`endif
                state_d = S_FILL;
            end
            S_FILL: begin
                if (w_can_load) begin
                    if (mode_q == MODE_AXI) begin
                        w_tready = 1'b1;
                        if (s_axis_tvalid) begin
                            w_load    = 1'b1;
                            w_ld_data = s_axis_tdata;
                            w_ld_last = s_axis_tlast;
                        end
                    end else begin
                        w_load = 1'b1;
                        if (mode_q == MODE_PRBS) begin
                            w_ld_data = w_prbs_byte;
                            prbs_d    = w_prbs_next;
                        end
                    end
                end
            end
            S_PAD: begin
                if (w_can_load) begin
                    w_load    = 1'b1;
                    w_ld_data = PAD_BYTE;
                    w_ld_pad  = 1'b1;
                end
            end
`ifdef TX_FRAMER_CRC_EN
            S_CRC: begin
                if (w_can_load) begin
                    w_load    = 1'b1;
                    w_ld_data = (idx_q == LAST_IDX) ? DAT_W'(crc_q[7:0])
                                                    : DAT_W'(crc_q[15:8]);
                end
            end
`endif
            S_GAP: begin
                // The oeop byte may still be waiting in the output register;
                // the idle count starts only once it has gone.
                if (oval_q) begin
                    if (w_xfer && (GAP_LEN == 0)) begin
                        state_d = S_IDLE;
                    end
                end else if ((GAP_LEN == 0) || (gap_q == GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            oval_d  = 1'b1;
            odata_d = w_ld_data;
            osop_d  = (idx_q == '0);
            oeop_d  = (idx_q == LAST_IDX);
            opad_d  = w_ld_pad;
            idx_d   = idx_q + IDX_W'(1);
`ifdef TX_FRAMER_CRC_EN
            if (state_q != S_CRC) begin
                crc_d = crc16_upd(crc_q, w_ld_data);
            end
`endif
            // Without CRC the payload end and block end coincide, so the
            // first branch always wins there.
            if (idx_q == LAST_IDX) begin
                state_d = S_GAP;
            end else if (idx_q == PAY_LAST_IDX) begin
                state_d = S_CRC;
            end else if (w_ld_last) begin
                state_d = S_PAD;
            end
        end
    end

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_AXI;
            idx_q   <= '0;
            gap_q   <= '0;
            prbs_q  <= '1;
            oval_q  <= 1'b0;
            odata_q <= '0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            opad_q  <= 1'b0;
            blk_q   <= '0;
            pad_q   <= '0;
`ifdef TX_FRAMER_CRC_EN
            crc_q   <= 16'hFFFF;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            prbs_q  <= prbs_d;
            oval_q  <= oval_d;
            odata_q <= odata_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            opad_q  <= opad_d;
            blk_q   <= blk_d;
            pad_q   <= pad_d;
`ifdef TX_FRAMER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign s_axis_tready = w_tready;
    assign oval          = oval_q;
    assign odata         = odata_q;
    assign osop          = osop_q;
    assign oeop          = oeop_q;
    assign blk_cnt       = blk_q;
    assign pad_cnt       = pad_q;

endmodule

`default_nettype wire
